// File: rtl/sha_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// sha_block_sequencer_if
//   Block stream, hashing-core and digest handshake bundle for the sequencer.
//   Rev 1.0
// ============================================================================
interface sha_block_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode;
  logic [1023:0]    blk_data;
  logic             blk_valid;
  logic             blk_last;
  logic             blk_ready;
  logic [1023:0]    core_M;
  logic [511:0]     core_H_in;
  logic             core_mode;
  logic             core_run;
  logic             core_ready;
  logic             core_done;
  logic [511:0]     core_hash;
  logic [511:0]     digest;
  logic             digest_valid;
  logic             digest_ack;
  logic             busy;
  logic [CNT_W-1:0] blk_count;

  modport master (
    input  start, mode, blk_data, blk_valid, blk_last,
           core_ready, core_done, core_hash, digest_ack,
    output blk_ready, core_M, core_H_in, core_mode, core_run,
           digest, digest_valid, busy, blk_count
  );

  modport slave (
    output start, mode, blk_data, blk_valid, blk_last,
           core_ready, core_done, core_hash, digest_ack,
    input  blk_ready, core_M, core_H_in, core_mode, core_run,
           digest, digest_valid, busy, blk_count
  );
endinterface
`default_nettype wire

// File: rtl/sha_block_sequencer.sv
`default_nettype none
// ============================================================================
// sha_block_sequencer
//   Multi-block SHA-256/512 message controller: IV select, per-block core run,
//   hash chaining, hold-until-ack digest. Optional macro SEQ_ABORT_EN.
//   Rev 1.0
// ============================================================================
module sha_block_sequencer #(
  parameter int CNT_W    = 16,
  parameter bit IDLE_CLR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SEQ_ABORT_EN
  input  logic                  abort,
`endif
  sha_block_sequencer_if.master bus
);

  localparam logic [511:0] IV_SHA512 = 512'h6a09e667f3bcc908bb67ae8584caa73b3c6ef372fe94f82ba54ff53a5f1d36f1510e527fade682d19b05688c2b3e6c1f1f83d9abfb41bd6b5be0cd19137e2179;
  localparam logic [511:0] IV_SHA256 = {256'h0, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
`ifdef SEQ_ABORT_EN
    , S_DRAIN = 3'd5
`endif
  } state_e;

  state_e           state_q;
  logic             mode_q;
  logic             last_q;
  logic [1023:0]    m_q;
  logic [511:0]     h_q;
  logic [511:0]     digest_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_abort;

`ifdef SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // SHA-256 uses only the low half of each bus; upper bits are forced to zero.
  function automatic logic [511:0] fit_h(input logic m, input logic [511:0] h);
    return m ? h : {256'h0, h[255:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      m_q      <= '0;
      h_q      <= '0;
      digest_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            h_q     <= bus.mode ? IV_SHA512 : IV_SHA256;
            cnt_q   <= '0;
            state_q <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (w_abort) begin
            state_q <= S_IDLE;
          end else if (bus.blk_valid) begin
            m_q     <= mode_q ? bus.blk_data : {512'h0, bus.blk_data[511:0]};
            last_q  <= bus.blk_last;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_abort) begin
            state_q <= S_IDLE;
          end else if (bus.core_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort) begin
`ifdef SEQ_ABORT_EN
            state_q <= bus.core_done ? S_IDLE : S_DRAIN;
`else
            state_q <= S_IDLE;
`endif
          end else if (bus.core_done) begin
            h_q <= fit_h(mode_q, bus.core_hash);
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (last_q) begin
              digest_q <= fit_h(mode_q, bus.core_hash);
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_ACCEPT;
            end
          end
        end
        S_DONE: begin
          if (w_abort || bus.digest_ack) begin
            state_q <= S_IDLE;
            if (IDLE_CLR) begin
              digest_q <= '0;
            end
          end
        end
`ifdef SEQ_ABORT_EN
        S_DRAIN: begin
          if (bus.core_done) begin
            state_q <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // core_run must fire in the very cycle core_ready is seen in ISSUE.
  assign bus.core_run     = (state_q == S_ISSUE) & bus.core_ready & ~w_abort;
  assign bus.blk_ready    = (state_q == S_ACCEPT);
  assign bus.digest_valid = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.core_M       = m_q;
  assign bus.core_H_in    = h_q;
  assign bus.core_mode    = mode_q;
  assign bus.digest       = digest_q;
  assign bus.blk_count    = cnt_q;

endmodule
`default_nettype wire

// File: doc/sha_block_sequencer.md
Name: sha_block_sequencer

Overview:
Multi-block message controller for the SHA hashing core. Accepts pre-padded message blocks over a valid/ready stream and selects the initial hash value by mode. Issues one core run per block, chains each block's result into the next block's H_in, and presents the final digest with a hold-until-ack handshake. Sits between the host/padding front-end and the hashing core.

Parameters:
CNT_W, 16, width of the processed-block counter
IDLE_CLR, 1, when 1, the digest output is driven to zero outside the DONE state; when 0, it holds the last digest

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse that begins a new message
mode  in  1  0 = SHA-256, 1 = SHA-512; sampled only when start is accepted
blk_data  in  1024  padded message block, word 0 at the MSB
blk_valid  in  1  block present
blk_last  in  1  final block of the message, qualified by blk_valid
blk_ready  out  1  sequencer can take a block
core_M  out  1024  block to the core
core_H_in  out  512  chaining value to the core
core_mode  out  1  latched mode
core_run  out  1  one-cycle start pulse to the core
core_ready  in  1  core idle and able to accept run
core_done  in  1  one-cycle pulse; core_hash valid in the same cycle
core_hash  in  512  post-feed-forward hash from the core
digest  out  512  final hash value
digest_valid  out  1  digest available
digest_ack  in  1  consumer takes the digest
busy  out  1  high in every state except IDLE
blk_count  out  CNT_W  number of blocks completed for the current message

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; every output=0, including blk_ready, core_run, digest_valid, busy, blk_count, core_M, core_H_in, digest and core_mode.
- Mode and width layout: in SHA-256 mode, only core_M[511:0] and core_H_in[255:0] are used; the upper bits are driven to 0, and blk_data[511:0] is the block. The digest is H_reg[255:0], zero-extended.
- IV values (FIPS 180-4), with H0 at the MSB:
  - SHA-512 IV is 5.3.5: 6a09e667f3bcc908 ... 5be0cd19137e2179.
  - SHA-256 IV is 5.3.3: 6a09e667 ... 5be0cd19.
- State machine:
  - IDLE: blk_ready=0. On start: latch mode, load H_reg with IV(mode), clear blk_count, go to ACCEPT. blk_valid is ignored in IDLE.
  - ACCEPT: blk_ready=1. On blk_valid & blk_ready: register the block into M_reg, register blk_last into last_reg, go to ISSUE.
  - ISSUE: blk_ready=0. When core_ready=1, core_run=1 for exactly that cycle, then go to WAIT. While core_ready=0, stay in ISSUE with core_run=0.
  - WAIT: on core_done, set H_reg <= core_hash and blk_count <= blk_count+1. If last_reg=1 go to DONE, else go to ACCEPT.
  - DONE: digest_valid=1, digest=H_reg. On digest_ack, go to IDLE in the next cycle with digest_valid=0.
- Stability and timing:
  - core_M, core_H_in and core_mode stay stable from entry to ISSUE until core_done.
  - Minimum overhead per block is 3 cycles outside core latency: accept, issue, done-to-accept.
- Boundary conditions:
  - start while busy=1 is ignored; mode is not re-sampled.
  - core_done outside WAIT is ignored, with no state change.
  - blk_count saturates at all-ones; chaining continues regardless.
  - start and digest_ack in the same DONE cycle: digest_ack is honoured, start is ignored, and the next start is accepted from IDLE.
  - rst mid-message: immediate return to IDLE with all outputs 0. The core is reset by the same rst.

Optional Feature:
SEQ_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort in ACCEPT, ISSUE or DONE returns to IDLE in the next cycle with digest_valid=0.
  - abort in WAIT moves to a DRAIN state that waits for core_done, discards core_hash, then goes to IDLE. busy stays 1 in DRAIN.
- Undefined: no abort port and no DRAIN state.

Test Plan:
- SHA-256 single block "abc" (padded), mode=0, core_ready=1 -> exactly one core_run pulse; digest[255:0]=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; blk_count=1.
- SHA-512 "abc", mode=1 -> digest=ddaf35a193617aba...a54ca49f; core_H_in equals the SHA-512 IV at run.
- SHA-256 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two core_run pulses; the second core_H_in equals the first core_hash; digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; blk_count=2.
- core_ready held 0 for 10 cycles in ISSUE -> core_run stays 0, then pulses once in the first cycle core_ready=1; core_M stays stable throughout.
- Hold digest_ack=0 for 20 cycles and pulse start meanwhile -> digest_valid held, digest unchanged, start ignored. After the ack, a new start in IDLE begins a fresh message.
- With SEQ_ABORT_EN defined, assert abort during WAIT -> DRAIN until core_done; H_reg is not updated; state returns to IDLE with busy=0 the cycle after core_done.
